// File: rtl/sys_ctrl_tx_resp_if.sv
// ---------------------------------------------------------------------------
// sys_ctrl_tx_resp_if
// Bundles the response-side signals of the system controller.
//   Response inputs : RdData / RdData_Valid (register file),
//                     ALU_OUT / OUT_Valid (ALU)
//   UART TX side    : TX_busy (in), TX_P_DATA / TX_D_VLD (out)
//   Status          : Ctrl_Busy, Resp_Drop (out)
// Modports:
//   master : the controller itself
//   slave  : the environment (RegFile/ALU sources and UART TX sink)
//
// Handshake: RdData_Valid and OUT_Valid are one-cycle strobes qualifying their
// data. Toward UART TX, TX_D_VLD is a one-cycle pulse qualifying TX_P_DATA and
// the next byte is only offered after TX_busy has been seen high and then low
// again (pulse-and-busy handshake; there is no ready signal).
// ---------------------------------------------------------------------------
interface sys_ctrl_tx_resp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic [ALU_WIDTH-1:0]  ALU_OUT;
  logic                  OUT_Valid;
  logic                  TX_busy;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  Ctrl_Busy;
  logic                  Resp_Drop;

  modport master (
    input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_busy,
    output TX_P_DATA, TX_D_VLD, Ctrl_Busy, Resp_Drop
  );

  modport slave (
    output RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_busy,
    input  TX_P_DATA, TX_D_VLD, Ctrl_Busy, Resp_Drop
  );
endinterface

// File: rtl/sys_ctrl_tx_resp.sv
// ---------------------------------------------------------------------------
// sys_ctrl_tx_resp
// Response-side system controller. Captures register-file read data and ALU
// results and serialises them as bytes to the UART transmitter.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   bus          sys_ctrl_tx_resp_if.master (response inputs, TX outputs,
//                Ctrl_Busy, Resp_Drop)
//   Frame_Cnt    [7:0] count of TX_D_VLD pulses, only when
//                SYS_CTRL_TX_FRAME_CNT_EN is defined
//   dbg_state_o  current FSM state, for debug/observation
//
// Optional feature macro: SYS_CTRL_TX_FRAME_CNT_EN
//
// Ordering: RF byte first (if any), then ALU low byte, then ALU high byte.
// ALU_WIDTH must equal 2*DATA_WIDTH.
// ---------------------------------------------------------------------------
module sys_ctrl_tx_resp #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  sys_ctrl_tx_resp_if.master    bus,
`ifdef SYS_CTRL_TX_FRAME_CNT_EN
  output logic [7:0]            Frame_Cnt,
`endif
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_RF = 3'd1,
    SEND_LO = 3'd2,
    SEND_HI = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  // Which byte is currently in flight; decides the step after WAIT_LO.
  typedef enum logic [1:0] {
    SEL_RF = 2'd0,
    SEL_LO = 2'd1,
    SEL_HI = 2'd2
  } sel_t;

  state_t                state_q, state_d;
  sel_t                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rf_q, rf_d;
  logic [ALU_WIDTH-1:0]  alu_q, alu_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rf_d    = rf_q;
    alu_d   = alu_q;
    pend_d  = pend_q;
    data_d  = data_q;     // TX_P_DATA holds between bytes
    vld_d   = 1'b0;
    drop_d  = 1'b0;

    // Strobes outside IDLE are discarded; the transfer is not disturbed.
    if (state_q != IDLE && (bus.RdData_Valid || bus.OUT_Valid)) begin
      drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.RdData_Valid) begin
          rf_d    = bus.RdData;
          state_d = SEND_RF;
          if (bus.OUT_Valid) begin
            alu_d  = bus.ALU_OUT;
            pend_d = 1'b1;
          end
        end else if (bus.OUT_Valid) begin
          alu_d   = bus.ALU_OUT;
          state_d = SEND_LO;
        end
      end
      SEND_RF, SEND_LO, SEND_HI: begin
        if (!bus.TX_busy) begin
          vld_d   = 1'b1;
          state_d = WAIT_HI;
          if (state_q == SEND_RF) begin
            data_d = rf_q;
            sel_d  = SEL_RF;
          end else if (state_q == SEND_LO) begin
            data_d = alu_q[DATA_WIDTH-1:0];
            sel_d  = SEL_LO;
          end else begin
            data_d = alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
            sel_d  = SEL_HI;
          end
        end
      end
      WAIT_HI: begin
        if (bus.TX_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!bus.TX_busy) begin
          case (sel_q)
            SEL_RF: begin
              if (pend_q) begin
                pend_d  = 1'b0;
                state_d = SEND_LO;
              end else begin
                state_d = IDLE;
              end
            end
            SEL_LO:  state_d = SEND_HI;
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= SEL_RF;
      rf_q    <= '0;
      alu_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rf_q    <= rf_d;
      alu_q   <= alu_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      drop_q  <= drop_d;
    end
  end

`ifdef SYS_CTRL_TX_FRAME_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counts in step with the TX_D_VLD register so the value is updated on the
  // same edge the pulse appears; 8-bit arithmetic wraps 255 -> 0.
  always_comb begin
    cnt_d = cnt_q;
    if (vld_d) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Frame_Cnt = cnt_q;
`endif

  assign bus.TX_P_DATA = data_q;
  assign bus.TX_D_VLD  = vld_q;
  assign bus.Resp_Drop = drop_q;
  assign bus.Ctrl_Busy = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sys_ctrl_tx_resp.sv
// ---------------------------------------------------------------------------
// tb_sys_ctrl_tx_resp
// Directed and randomized checks of sys_ctrl_tx_resp against a byte-list
// reference model. A UART TX model raises TX_busy for busy_len cycles after
// every TX_D_VLD pulse.
// ---------------------------------------------------------------------------
module tb_sys_ctrl_tx_resp;
  localparam int DW = 8;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sys_ctrl_tx_resp_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) bus ();
  logic [2:0] dbg_state;
`ifdef SYS_CTRL_TX_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  sys_ctrl_tx_resp #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
`ifdef SYS_CTRL_TX_FRAME_CNT_EN
    .Frame_Cnt   (frame_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int  vld_seen  = 0;
  int  drop_seen = 0;
  int  busy_len  = 3;
  int  busy_cnt  = 0;
  bit  hold_busy = 1'b0;
  bit  prev_vld  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- UART TX model ----------------
  initial begin
    bus.TX_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (busy_cnt > 0) busy_cnt--;
      if (bus.TX_D_VLD === 1'b1) busy_cnt = busy_len;
      bus.TX_busy = hold_busy || (busy_cnt > 0);
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.TX_D_VLD === 1'b1) begin
        vld_seen++;
        chk("vld_one_cycle", {31'd0, prev_vld}, 32'd0);
        chk("vld_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("tx_byte", bus.TX_P_DATA, exp_q.pop_front());
      end
      prev_vld = (bus.TX_D_VLD === 1'b1);
      if (bus.Resp_Drop === 1'b1) drop_seen++;
    end
  end

  // ---------------- reference model ----------------
  // kind: 0 = RF only, 1 = ALU only, 2 = both in the same cycle
  task automatic model_push(input int kind, input logic [7:0] r, input logic [15:0] a);
    if (kind != 1) exp_q.push_back(r);
    if (kind != 0) begin
      exp_q.push_back(a[7:0]);
      exp_q.push_back(a[15:8]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input bit rv, input bit ov, input logic [7:0] r, input logic [15:0] a);
    bus.RdData       = r;
    bus.ALU_OUT      = a;
    bus.RdData_Valid = rv;
    bus.OUT_Valid    = ov;
    @(negedge CLK);
    bus.RdData_Valid = 1'b0;
    bus.OUT_Valid    = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    for (int i = 0; i < 200 && bus.TX_D_VLD !== 1'b1; i++) @(negedge CLK);
    chk(tag, {31'd0, bus.TX_D_VLD}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int stable = 0;
    for (int i = 0; i < 400 && stable < 2; i++) begin
      @(negedge CLK);
      if (bus.Ctrl_Busy === 1'b0 && bus.TX_busy === 1'b0) stable++;
      else stable = 0;
    end
    chk(tag, {31'd0, bus.Ctrl_Busy}, 32'd0);
    chk({tag, "_all_sent"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int v0, d0, exp_drop, kind;
    logic [7:0]  r;
    logic [15:0] a;

    RST = 1'b1;
    bus.RdData = '0; bus.RdData_Valid = 1'b0;
    bus.ALU_OUT = '0; bus.OUT_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx_data", bus.TX_P_DATA, 32'h0);
    chk("rst_tx_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    chk("rst_busy", {31'd0, bus.Ctrl_Busy}, 32'd0);
    chk("rst_drop", {31'd0, bus.Resp_Drop}, 32'd0);
`ifdef SYS_CTRL_TX_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 32'd0);
`endif
    RST = 1'b0;
    @(negedge CLK);

    // RF byte, latency N+2, single-cycle pulse
    busy_len = 3;
    model_push(0, 8'h5A, 16'h0);
    pulse(1'b1, 1'b0, 8'h5A, 16'h0);
    chk("lat_n1_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    chk("lat_n1_busy", {31'd0, bus.Ctrl_Busy}, 32'd1);
    @(negedge CLK);
    chk("lat_n2_vld", {31'd0, bus.TX_D_VLD}, 32'd1);
    chk("lat_n2_data", bus.TX_P_DATA, 32'h5A);
    @(negedge CLK);
    chk("lat_n3_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    chk("hold_data", bus.TX_P_DATA, 32'h5A);
    wait_idle("rf_idle");

    // ALU result, slow TX
    busy_len = 10;
    v0 = vld_seen;
    model_push(1, 8'h0, 16'h1234);
    pulse(1'b0, 1'b1, 8'h0, 16'h1234);
    wait_idle("alu_idle");
    chk("alu_pulses", vld_seen - v0, 32'd2);

    // Both strobes together
    busy_len = 4;
    v0 = vld_seen; d0 = drop_seen;
    model_push(2, 8'hA5, 16'hBEEF);
    pulse(1'b1, 1'b1, 8'hA5, 16'hBEEF);
    wait_idle("both_idle");
    chk("both_pulses", vld_seen - v0, 32'd3);
    chk("both_no_drop", drop_seen - d0, 32'd0);

    // Strobe while in WAIT_LO is dropped
    v0 = vld_seen; d0 = drop_seen;
    model_push(0, 8'h11, 16'h0);
    pulse(1'b1, 1'b0, 8'h11, 16'h0);
    wait_vld("drop_vld");
    repeat (2) @(negedge CLK);
    pulse(1'b0, 1'b1, 8'h0, 16'($urandom));
    wait_idle("drop_idle");
    chk("drop_count", drop_seen - d0, 32'd1);
    chk("drop_pulses", vld_seen - v0, 32'd1);

    // TX busy on entry to SEND_RF
    hold_busy = 1'b1;
    repeat (2) @(negedge CLK);
    v0 = vld_seen;
    model_push(0, 8'h77, 16'h0);
    pulse(1'b1, 1'b0, 8'h77, 16'h0);
    repeat (20) @(negedge CLK);
    chk("held_no_vld", vld_seen - v0, 32'd0);
    chk("held_busy", {31'd0, bus.Ctrl_Busy}, 32'd1);
    hold_busy = 1'b0;
    wait_idle("held_idle");
    chk("held_pulses", vld_seen - v0, 32'd1);

    // Reset during WAIT_HI of the ALU low byte
    busy_len = 10;
    exp_q.push_back(8'hCD);   // high byte must never go out
    pulse(1'b0, 1'b1, 8'h0, 16'hABCD);
    wait_vld("rst_mid_vld");
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_data", bus.TX_P_DATA, 32'h0);
    chk("rst_mid_vld0", {31'd0, bus.TX_D_VLD}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.Ctrl_Busy}, 32'd0);
    chk("rst_mid_drop", {31'd0, bus.Resp_Drop}, 32'd0);
`ifdef SYS_CTRL_TX_FRAME_CNT_EN
    chk("rst_mid_frame_cnt", frame_cnt, 32'd0);
`endif
    RST = 1'b0;
    v0 = vld_seen;
    repeat (30) @(negedge CLK);
    chk("rst_mid_no_hi", vld_seen - v0, 32'd0);
    wait_idle("rst_mid_idle");

    // Randomized transfers with optional in-flight drop strobes
    for (int it = 0; it < 24; it++) begin
      busy_len = $urandom_range(1, 6);
      kind = $urandom_range(0, 2);
      r = 8'($urandom);
      a = 16'($urandom);
      v0 = vld_seen; d0 = drop_seen; exp_drop = 0;
      model_push(kind, r, a);
      pulse(kind != 1, kind != 0, r, a);
      if ($urandom_range(0, 1) == 1) begin
        wait_vld("rand_vld");
        pulse(1'b1, $urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom));
        exp_drop = 1;
      end
      wait_idle("rand_idle");
      chk("rand_pulses", vld_seen - v0, (kind == 0) ? 32'd1 : (kind == 1) ? 32'd2 : 32'd3);
      chk("rand_drops", drop_seen - d0, exp_drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_tx_resp.md
Name: sys_ctrl_tx_resp

Overview:
- Response-side system controller: the transmit-direction counterpart of the RX command decoder.
- Collects register-file read data (RdData/RdData_Valid) and ALU results (ALU_OUT/OUT_Valid).
- Serialises them into bytes for the UART transmitter using a pulse-and-busy handshake.
- Sits between RegFile/ALU outputs and the UART TX data path (through the data-sync stage where one exists).

Parameters:
- DATA_WIDTH, 8, byte width sent to UART TX.
- ALU_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Valid  in  1  one-cycle strobe; RdData is valid.
- ALU_OUT  in  ALU_WIDTH  ALU result.
- OUT_Valid  in  1  one-cycle strobe; ALU_OUT is valid.
- TX_busy  in  1  UART TX is busy serialising a frame.
- TX_P_DATA  out  DATA_WIDTH  byte presented to UART TX.
- TX_D_VLD  out  1  one-cycle strobe; TX_P_DATA is valid.
- Ctrl_Busy  out  1  high whenever state != IDLE.
- Resp_Drop  out  1  one-cycle pulse; a response strobe was discarded.

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE; TX_P_DATA=0, TX_D_VLD=0, Resp_Drop=0, Ctrl_Busy=0. Capture registers and pending flag are cleared. Reset mid-transfer aborts with no further TX_D_VLD.
- All outputs are registered, except Ctrl_Busy, which is decoded from state.
- States: IDLE, SEND_RF, SEND_LO, SEND_HI, WAIT_HI, WAIT_LO.
- IDLE:
  - RdData_Valid: latch RdData; go to SEND_RF.
  - Else OUT_Valid: latch ALU_OUT; go to SEND_LO.
  - Both strobes in the same cycle: both are latched; ALU_pend is set; go to SEND_RF. The RF byte goes out first, then the ALU bytes.
- SEND_x, with TX_busy=0: next edge drives TX_D_VLD=1, TX_P_DATA=selected byte, state=WAIT_HI.
  - Byte selection: SEND_RF sends the RF byte; SEND_LO sends ALU[7:0]; SEND_HI sends ALU[15:8].
- SEND_x, with TX_busy=1: hold; TX_D_VLD stays 0.
- WAIT_HI: TX_D_VLD returns to 0 on the next edge (exactly one-cycle pulse per byte); stay until TX_busy=1, then go to WAIT_LO.
- WAIT_LO: stay until TX_busy=0, then go to the next step:
  - after the RF byte: SEND_LO if ALU_pend=1 (clear ALU_pend), else IDLE;
  - after the LO byte: SEND_HI;
  - after the HI byte: IDLE.
- Byte order for ALU results: low byte first, then high byte.
- Latency: with TX idle, a strobe in cycle N gives TX_D_VLD=1 in cycle N+2.
- Any RdData_Valid or OUT_Valid seen while state != IDLE is discarded. Resp_Drop pulses in the following cycle; the in-flight transfer is unaffected.
- TX_P_DATA holds its last value between strobes.

Optional Feature:
- Macro: SYS_CTRL_TX_FRAME_CNT_EN.
- Defined:
  - adds output port Frame_Cnt [7:0];
  - increments by 1 on each TX_D_VLD pulse and wraps 255->0;
  - cleared by RST.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- RdData=0x5A with RdData_Valid pulse, TX_busy=0 -> TX_D_VLD one cycle, TX_P_DATA=0x5A, 2 cycles after the strobe; IDLE after TX_busy falls.
- ALU_OUT=0x1234 with OUT_Valid, TX model busy 10 cycles per byte -> bytes 0x34 then 0x12, exactly 2 TX_D_VLD pulses.
- Same-cycle RdData=0xA5 and ALU_OUT=0xBEEF -> byte sequence 0xA5, 0xEF, 0xBE; Resp_Drop never asserted.
- OUT_Valid during a transfer in WAIT_LO -> Resp_Drop pulses once; original sequence completes unchanged; no extra TX_D_VLD.
- TX_busy held 1 on entry to SEND_RF for 20 cycles -> TX_D_VLD stays 0 until TX_busy drops.
- RST asserted during WAIT_HI of the ALU low byte -> all outputs 0 next cycle, no high byte sent; Frame_Cnt=0 when SYS_CTRL_TX_FRAME_CNT_EN is defined.
